// File: rtl/clean_reminder_ctrl.sv
// Cleaning-reminder controller: blinks the reminder LED, runs timed
// auto-clean cycles and confirms a hold-to-clear manual reset.
module clean_reminder_ctrl #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int CLEAN_SECONDS = 180,
  parameter int HOLD_SECONDS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       time_out,
  input  logic       power_on,
  input  logic       auto_clean_req,
  input  logic       hand_clean_btn,
  output logic       if_clean,
  output logic       if_hand_clean,
  output logic       reminder_led,
  output logic       cleaning,
  output logic [7:0] clean_remaining
);

  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HALF = (CLK_HZ / 2 > 1) ? CLK_HZ / 2 : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SW   = 4;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);
  localparam logic [SW-1:0] HOLD_LAST = SW'(HOLD_SECONDS - 1);
  localparam logic [7:0]    CLEAN_INI = 8'(CLEAN_SECONDS);

  typedef enum logic [1:0] {
    IDLE, REMIND, CLEANING, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [SW-1:0] hsec_q, hsec_d;
  logic          armed_q, armed_d;
  logic          btn_q;
  logic          led_d, cln_d, ifc_d, ifh_d;
  logic [7:0]    rem_d;
  logic          tick, btn_rise, hold_done;

  assign tick      = (presc_q == PRESC_MAX);
  assign btn_rise  = hand_clean_btn & ~btn_q;
  assign hold_done = armed_q & hand_clean_btn & tick &
                     (hsec_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    blink_d = blink_q;
    hsec_d  = hsec_q;
    armed_d = armed_q;
    led_d   = reminder_led;
    cln_d   = 1'b0;
    ifc_d   = 1'b0;
    ifh_d   = 1'b0;
    rem_d   = clean_remaining;
    unique case (state_q)
      IDLE, REMIND: begin
        if (armed_q) begin
          if (!hand_clean_btn) armed_d = 1'b0;
          else if (tick) hsec_d = hsec_q + 1'b1;
        end else if (btn_rise) begin
          armed_d = 1'b1;
          presc_d = '0;
          hsec_d  = '0;
        end
        if (state_q == REMIND) begin
          if (blink_q == BLINK_MAX) begin
            blink_d = '0;
            led_d   = ~reminder_led;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
        if (hold_done) begin
          state_d = IDLE;
          ifh_d   = 1'b1;
          armed_d = 1'b0;
          hsec_d  = '0;
          led_d   = 1'b0;
        end else if (auto_clean_req && power_on) begin
          state_d = CLEANING;
          cln_d   = 1'b1;
          rem_d   = CLEAN_INI;
          presc_d = '0;
          armed_d = 1'b0;
          led_d   = 1'b0;
        end else if (state_q == IDLE && time_out) begin
          state_d = REMIND;
          led_d   = 1'b1;
          blink_d = '0;
        end else if (state_q == REMIND && !time_out) begin
          state_d = IDLE;
          led_d   = 1'b0;
        end
      end
      CLEANING: begin
        cln_d = 1'b1;
        led_d = 1'b0;
        if (!power_on) begin
          cln_d = 1'b0;
          rem_d = '0;
          if (time_out) begin
            state_d = REMIND;
            led_d   = 1'b1;
            blink_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (tick) begin
          if (clean_remaining == 8'd1) begin
            state_d = DONE;
            rem_d   = '0;
            cln_d   = 1'b0;
            ifc_d   = 1'b1;
          end else begin
            rem_d = clean_remaining - 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        led_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        led_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      presc_q         <= '0;
      blink_q         <= '0;
      hsec_q          <= '0;
      armed_q         <= 1'b0;
      btn_q           <= 1'b0;
      reminder_led    <= 1'b0;
      cleaning        <= 1'b0;
      if_clean        <= 1'b0;
      if_hand_clean   <= 1'b0;
      clean_remaining <= '0;
    end else begin
      state_q         <= state_d;
      presc_q         <= presc_d;
      blink_q         <= blink_d;
      hsec_q          <= hsec_d;
      armed_q         <= armed_d;
      btn_q           <= hand_clean_btn;
      reminder_led    <= led_d;
      cleaning        <= cln_d;
      if_clean        <= ifc_d;
      if_hand_clean   <= ifh_d;
      clean_remaining <= rem_d;
    end
  end

endmodule

// File: tb/tb_clean_reminder_ctrl.sv
// Directed bench for clean_reminder_ctrl with a 10-cycle second,
// 3 s clean and 2 s hold.
module tb_clean_reminder_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       time_out;
  logic       power_on;
  logic       auto_clean_req;
  logic       hand_clean_btn;
  logic       if_clean;
  logic       if_hand_clean;
  logic       reminder_led;
  logic       cleaning;
  logic [7:0] clean_remaining;

  int checks = 0;
  int errors = 0;

  clean_reminder_ctrl #(
    .CLK_HZ(10),
    .CLEAN_SECONDS(3),
    .HOLD_SECONDS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .time_out(time_out),
    .power_on(power_on),
    .auto_clean_req(auto_clean_req),
    .hand_clean_btn(hand_clean_btn),
    .if_clean(if_clean),
    .if_hand_clean(if_hand_clean),
    .reminder_led(reminder_led),
    .cleaning(cleaning),
    .clean_remaining(clean_remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, if_clean, if_hand_clean,
            reminder_led, cleaning, clean_remaining};
  endfunction

  initial begin
    reset          = 1'b1;
    time_out       = 1'b0;
    power_on       = 1'b0;
    auto_clean_req = 1'b0;
    hand_clean_btn = 1'b0;
    repeat (3) step();
    check("reset_outs", outs(), 32'd0);
    reset = 1'b0;
    step();
    check("idle_outs", outs(), 32'd0);

    time_out = 1'b1;
    step();
    check("blink_0", reminder_led, 1'b1);
    for (int i = 1; i < 20; i++) begin
      step();
      check("blink", reminder_led, ((i / 5) % 2) == 0);
    end
    time_out = 1'b0;
    step();
    check("remind_exit", reminder_led, 1'b0);
    step();
    check("idle_led", reminder_led, 1'b0);

    power_on       = 1'b1;
    auto_clean_req = 1'b1;
    step();
    auto_clean_req = 1'b0;
    check("clean_entry", {cleaning, clean_remaining}, {1'b1, 8'd3});
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k < 30)
        check("clean_run",
              {if_clean, cleaning, clean_remaining},
              {1'b0, 1'b1, 8'(3 - k / 10)});
      else
        check("clean_done",
              {if_clean, cleaning, clean_remaining},
              {1'b1, 1'b0, 8'd0});
    end
    step();
    check("done_one_cycle", {if_clean, cleaning}, 2'b00);

    time_out       = 1'b1;
    auto_clean_req = 1'b1;
    step();
    auto_clean_req = 1'b0;
    check("to_and_req", {cleaning, clean_remaining}, {1'b1, 8'd3});
    repeat (14) step();
    check("pre_abort", clean_remaining, 8'd2);
    power_on = 1'b0;
    step();
    check("abort",
          {if_clean, cleaning, clean_remaining, reminder_led},
          {1'b0, 1'b0, 8'd0, 1'b1});
    for (int i = 1; i < 20; i++) begin
      step();
      check("abort_remind", {if_clean, reminder_led},
            {1'b0, ((i / 5) % 2) == 0});
    end

    hand_clean_btn = 1'b1;
    step();
    for (int k = 1; k < 20; k++) begin
      step();
      check("hold_wait", if_hand_clean, 1'b0);
    end
    step();
    check("hold_confirm", {if_hand_clean, reminder_led}, 2'b10);
    hand_clean_btn = 1'b0;
    step();
    check("after_confirm", {if_hand_clean, reminder_led}, 2'b01);

    hand_clean_btn = 1'b1;
    step();
    for (int k = 1; k < 20; k++) begin
      step();
      check("short_wait", if_hand_clean, 1'b0);
    end
    hand_clean_btn = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("short_release", if_hand_clean, 1'b0);
    end

    hand_clean_btn = 1'b1;
    step();
    for (int k = 1; k <= 50; k++) begin
      step();
      check("long_hold", if_hand_clean, k == 20);
    end
    hand_clean_btn = 1'b0;
    step();

    power_on       = 1'b1;
    hand_clean_btn = 1'b1;
    step();
    repeat (19) step();
    auto_clean_req = 1'b1;
    step();
    check("hand_vs_req", {if_hand_clean, cleaning}, 2'b10);
    auto_clean_req = 1'b0;
    hand_clean_btn = 1'b0;
    step();
    check("req_dropped", {if_hand_clean, cleaning}, 2'b00);

    time_out = 1'b0;
    step();
    auto_clean_req = 1'b1;
    step();
    auto_clean_req = 1'b0;
    repeat (12) step();
    check("pre_reset", {cleaning, clean_remaining}, {1'b1, 8'd2});
    reset = 1'b1;
    #1;
    check("async_reset", outs(), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      check("post_reset", outs(), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
